// File: rtl/cache_pkg.sv
// cache_pkg: shared geometry, FSM state type and address-field helpers for the data cache
package cache_pkg;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 10;
  localparam int INDEX_W = 5;
  localparam int OFF_W   = 2;
  localparam int CNT_W   = 32;
  localparam int TAG_W   = ADDR_W - INDEX_W - OFF_W;
  localparam int BLOCK_W = DATA_W * (2 ** OFF_W);
  typedef enum logic [1:0] {IDLE, RD_MISS, FILL, WR_THRU} cache_state_e;
  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1 -: TAG_W];
  endfunction
  function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
    return a[OFF_W +: INDEX_W];
  endfunction
  function automatic logic [OFF_W-1:0] addr_off(input logic [ADDR_W-1:0] a);
    return a[OFF_W-1:0];
  endfunction
endpackage

// File: rtl/cache_tag_store.sv
// cache_tag_store: per-line valid bits and tags with one write port and a combinational hit
module cache_tag_store
  import cache_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_we,
  input  logic [INDEX_W-1:0] i_idx,
  input  logic [TAG_W-1:0]   i_tag,
  output logic               o_hit
);
  logic [2**INDEX_W-1:0] r_valid;
  logic [TAG_W-1:0]      r_tag [2**INDEX_W];
  always_ff @(posedge clk or posedge rst)
    if (rst) r_valid <= '0;
    else if (i_we) r_valid[i_idx] <= 1'b1;
  // tags need no reset: a line is only trusted once its valid bit is set
  always_ff @(posedge clk)
    if (i_we) r_tag[i_idx] <= i_tag;
  assign o_hit = r_valid[i_idx] && (r_tag[i_idx] == i_tag);
endmodule

// File: rtl/dcache_controller.sv
// dcache_controller: write-through, no-write-allocate, direct-mapped cache sequencer
// with pipeline stall, block fill from memory and hit/miss counters
module dcache_controller
  import cache_pkg::*;
(
  input  logic               clk,
  input  logic               RST,
  input  logic               MemRead,
  input  logic               MemWrite,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [DATA_W-1:0]  WriteData,
  output logic               Stall,
  output logic [DATA_W-1:0]  ReadData_m,
  output logic [INDEX_W-1:0] da_index,
  output logic [OFF_W-1:0]   da_offset,
  output logic               da_word_we,
  output logic [DATA_W-1:0]  da_wdata,
  output logic               da_fill_we,
  output logic [BLOCK_W-1:0] da_fill_data,
  input  logic [DATA_W-1:0]  da_rdata,
  output logic               mem_req,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic               mem_ready,
  input  logic [BLOCK_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]   hit_cnt,
  output logic [CNT_W-1:0]   miss_cnt
);
  cache_state_e       r_state, w_next;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_wdata;
  logic [BLOCK_W-1:0] r_line;
  logic               r_filled;
  logic [CNT_W-1:0]   r_hit_cnt, r_miss_cnt;
  logic               w_idle, w_hit, w_req, w_count;
  logic [ADDR_W-1:0]  w_addr;
  assign w_idle = r_state == IDLE;
  assign w_addr = w_idle ? addr : r_addr;
  assign w_req  = MemRead || MemWrite;
  // the hit seen right after a fill is the same access re-evaluating, so it is not counted again
  assign w_count = w_idle && w_req && !(r_filled && MemRead && !MemWrite && w_hit);
  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
  cache_tag_store u_tags (
    .clk  (clk),
    .rst  (RST),
    .i_we (r_state == FILL),
    .i_idx(addr_index(w_addr)),
    .i_tag(addr_tag(w_addr)),
    .o_hit(w_hit)
  );
  always_ff @(posedge clk or posedge RST)
    if (RST) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_line     <= '0;
      r_filled   <= 1'b0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      r_state  <= w_next;
      r_filled <= r_state == FILL;
      if (w_idle && w_req) begin
        r_addr  <= addr;
        r_wdata <= WriteData;
      end
      if (r_state == RD_MISS && mem_ready) r_line <= mem_rdata;
      if (w_count && w_hit) r_hit_cnt <= r_hit_cnt + 1'b1;
      if (w_count && !w_hit) r_miss_cnt <= r_miss_cnt + 1'b1;
    end
  // outputs are decoded from state and forced low while reset is held
  always_comb begin
    w_next       = r_state;
    Stall        = 1'b0;
    ReadData_m   = '0;
    da_index     = '0;
    da_offset    = '0;
    da_word_we   = 1'b0;
    da_wdata     = '0;
    da_fill_we   = 1'b0;
    da_fill_data = '0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    if (!RST) begin
      ReadData_m   = da_rdata;
      da_index     = addr_index(w_addr);
      da_offset    = addr_off(w_addr);
      da_wdata     = r_wdata;
      da_fill_data = r_line;
      case (r_state)
        IDLE: begin
          Stall  = MemWrite || (MemRead && !w_hit);
          w_next = MemWrite ? WR_THRU : (MemRead && !w_hit) ? RD_MISS : IDLE;
        end
        RD_MISS: begin
          Stall    = 1'b1;
          mem_req  = 1'b1;
          mem_addr = {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          w_next   = mem_ready ? FILL : RD_MISS;
        end
        FILL: begin
          Stall      = 1'b1;
          da_fill_we = 1'b1;
          w_next     = IDLE;
        end
        WR_THRU: begin
          Stall      = !mem_ready;
          mem_req    = 1'b1;
          mem_we     = 1'b1;
          mem_addr   = r_addr;
          mem_wdata  = r_wdata;
          da_word_we = mem_ready && w_hit;
          w_next     = mem_ready ? IDLE : WR_THRU;
        end
        default: w_next = IDLE;
      endcase
    end
  end
endmodule
